pll_drp_ctrl: RTL

Initiator for the GW5A PLLA dynamic-reconfiguration (MD) port on the SNES clock PLL. It turns single register read/write requests from the system side into MDCLK/MDOPC/MDAINC/MDWDI sequences and captures MDRDO. After a write it supervises PLL LOCK before it reports completion. It sits beside the SNES PLL wrapper and lets the system change output dividers at runtime, for example to switch between NTSC and PAL clocks, without a rebuild.

---
 rtl/pll_drp_pkg.sv | 19 +
 rtl/md_phase_gen.sv | 31 +++
 rtl/pll_drp_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/pll_drp_pkg.sv
// Shared constants and types for the GW5A PLLA MD-port initiator.
package pll_drp_pkg;

  localparam int ADDR_W = 7;

  localparam logic [1:0] MD_NOP = 2'b00;
  localparam logic [1:0] MD_WR  = 2'b01;
  localparam logic [1:0] MD_RD  = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    SEEK,
    OP,
    RD_WAIT,
    LOCK_WAIT,
    DONE
  } state_e;

endpackage

// File: rtl/md_phase_gen.sv
// Two-phase divider for the MD port: phase 0 (md_clk low) then phase 1 (md_clk high).
module md_phase_gen (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic md_clk,
  output logic ph0,
  output logic ph1_end
);

  logic phase_q;
  logic phase_d;

  // Dropping run parks the divider in phase 0, so every burst starts with md_clk low.
  always_comb begin
    phase_d = run ? ~phase_q : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign md_clk  = phase_q;
  assign ph0     = run & ~phase_q;
  assign ph1_end = run & phase_q;

endmodule

// File: rtl/pll_drp_ctrl.sv
// MD-port initiator: seeks the PLL address pointer by increment, issues one read/write,
// captures MDRDO for reads and supervises LOCK after writes.
module pll_drp_ctrl
  import pll_drp_pkg::*;
#(
  parameter int LOCK_SETTLE  = 16,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [7:0]        req_wdata,
  output logic              resp_valid,
  output logic [7:0]        resp_rdata,
  output logic              resp_err,
  output logic              md_clk,
  output logic [1:0]        md_opc,
  output logic              md_ainc,
  output logic [7:0]        md_wdi,
  input  logic [7:0]        md_rdo,
  input  logic              pll_lock
);

  // Request handshake: a request transfers on the rising clk edge where req_valid && req_ready;
  // req_ready is high only in IDLE outside reset, and resp_valid is a single-cycle pulse.

  localparam logic [31:0] SETTLE_LAST  = (LOCK_SETTLE > 0) ? 32'(LOCK_SETTLE - 1) : 32'd0;
  localparam logic [31:0] TIMEOUT_LAST = SETTLE_LAST + 32'(LOCK_TIMEOUT);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_q, wr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [1:0]        lock_sync_q, lock_sync_d;

  logic run;
  logic ph_clk;
  logic ph0;
  logic ph1_end;

  assign run = (state_q == SEEK) || (state_q == OP) || (state_q == RD_WAIT);

  md_phase_gen u_phase (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .md_clk  (ph_clk),
    .ph0     (ph0),
    .ph1_end (ph1_end)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    addr_d      = addr_q;
    wr_d        = wr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    cnt_d       = '0;
    lock_sync_d = {lock_sync_q[0], pll_lock};

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          wr_d    = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          state_d = (req_addr != ptr_q) ? SEEK : OP;
        end
      end
      SEEK: begin
        // The shadow pointer steps as each increment cycle is launched, so by phase 1
        // it already shows where the PLL pointer lands after this md_clk rise.
        if (ph0) begin
          ptr_d = ptr_q + 7'd1;
        end
        if (ph1_end && (ptr_q == addr_q)) begin
          state_d = OP;
        end
      end
      OP: begin
        if (ph1_end) begin
          state_d = wr_q ? LOCK_WAIT : RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (ph1_end) begin
          rdata_d = md_rdo;
          state_d = DONE;
        end
      end
      LOCK_WAIT: begin
        cnt_d = cnt_q + 32'd1;
        if (cnt_q >= SETTLE_LAST) begin
          if (lock_sync_q[1]) begin
            state_d = DONE;
          end else if (cnt_q == TIMEOUT_LAST) begin
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      addr_q      <= '0;
      wr_q        <= 1'b0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      lock_sync_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      addr_q      <= addr_d;
      wr_q        <= wr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      lock_sync_q <= lock_sync_d;
    end
  end

  assign req_ready  = (state_q == IDLE) && !rst;
  assign resp_valid = (state_q == DONE);
  assign resp_err   = (state_q == DONE) && err_q;
  assign resp_rdata = rdata_q;

  // RD_WAIT keeps the divider running for timing but presents no md_clk edge to the PLL.
  assign md_clk  = ph_clk && ((state_q == SEEK) || (state_q == OP));
  assign md_ainc = (state_q == SEEK);
  assign md_opc  = (state_q == OP) ? (wr_q ? MD_WR : MD_RD) : MD_NOP;
  assign md_wdi  = ((state_q == OP) && wr_q) ? wdata_q : 8'h00;

endmodule
